dmem_mmio_responder: RTL and testbench
======================================

// Module: dmem_mmio_responder
// PURPOSE
//   Data-side memory responder for the single-cycle ARM core. Serves the
//   core's load/store port: ALUResult is the address, WriteData is the store
//   data, ReadData is the load data. It contains a word data RAM and a small
//   MMIO block with LED, switch and timer registers. Reads are combinational,
//   so loads complete in the same cycle. Stores commit on the rising clock edge.
// PARAMETERS
//   RAM_WORDS  64            data RAM depth in 32-bit words; must be a power of 2
//   MMIO_BASE  32'h0000_0800 MMIO page base; decode uses Addr[31:8] only
//   LED_W      16            LED register width
//   SW_W       16            switch input width
// PORTS
//   clk        in   1      core clock; all state changes on its rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   MemWrite   in   1      store strobe from the core controller
//   Addr       in   32     byte address (core ALUResult); Addr[1:0] ignored
//   WriteData  in   32     store data (core WriteData)
//   ReadData   out  32     load data, combinational from Addr and current state
//   sw_in      in   SW_W   asynchronous switch inputs
//   led_out    out  LED_W  registered LED outputs
//   irq        out  1      timer match flag AND CTRL.ie
// BEHAVIOUR
//   Address decode, with word index wi = Addr[31:2]:
//     - RAM hit when Addr < RAM_WORDS*4.
//     - MMIO hit when Addr[31:8] == MMIO_BASE[31:8].
//     - Any other address: reads return 0 and writes are ignored (no fault).
//   MMIO map (offset = Addr[7:0]):
//     0x00 LED    RW   bits [LED_W-1:0]; upper bits read 0
//     0x04 SW     RO   2-flop synchronised sw_in, zero-extended; writes ignored
//     0x08 CNT    RW   32-bit timer count; a write loads the count
//     0x0C CMP    RW   32-bit compare value
//     0x10 CTRL   RW   bit0 en, bit1 autoreload, bit2 flag (W1C), bit3 ie;
//                      all other bits read 0
//     Other offsets in the page read 0; writes to them are ignored.
//   Store: at a rising edge with MemWrite=1, the decoded target updates, and
//     the new value is visible on ReadData the following cycle.
//   Load: ReadData is a mux of current RAM/register contents. It has zero
//     latency and no read side effects.
//   RAM: not reset; contents are X until written. Full-word access only.
//   Timer, evaluated each edge in priority order:
//     1. A CNT write that cycle: CNT <= WriteData. No match check is made
//        that cycle.
//     2. Else, if en=1 and CNT==CMP: flag <= 1;
//        CNT <= autoreload ? 0 : CNT+1.
//     3. Else, if en=1: CNT <= CNT+1. 0xFFFF_FFFF wraps to 0 without
//        setting flag.
//     4. en=0: CNT holds.
//   CTRL write: en, autoreload and ie take WriteData bits 0, 1 and 3.
//     Writing 1 to bit2 clears flag; writing 0 to bit2 has no effect.
//     If a match sets flag in the same cycle a W1C clears it, the set wins
//     (flag stays 1).
//   sw path: sync1 <= sw_in; sync2 <= sync1. A change on sw_in reaches
//     ReadData@0x04 after 2 edges.
//   Reset (reset_n=0, asynchronous assert; synchronous-safe deassert is
//     handled upstream):
//     - LED=0, CNT=0, CMP=32'hFFFF_FFFF, CTRL=0 (flag=0), sync flops=0.
//     - Hence led_out=0 and irq=0.
//     - ReadData reflects these values combinationally.
//     - Reset mid-store: the store is lost. RAM contents are undefined after
//       reset only if never written; written RAM is retained.
// TESTING
//   1. RAM: store 0xDEADBEEF at 0x3C, then load 0x3C -> 0xDEADBEEF. Load
//      0x3E -> same value (Addr[1:0] ignored).
//   2. Decode: store at 0x400 (gap region), then load 0x400 -> 0. Store
//      0x1234 at 0x800 -> led_out=0x1234 one edge later; load 0x800 ->
//      0x0000_1234.
//   3. Timer: CMP=5, CTRL=0xB (en, autoreload, ie), CNT=0 -> flag and irq
//      go to 1 on the edge where CNT==5, then CNT=0. Write CTRL=0xF -> flag
//      clears; irq drops the next cycle.
//   4. Collision: a W1C of flag on the exact match cycle -> flag stays 1.
//      A CNT write on the match cycle -> CNT takes the written value and
//      flag does not set.
//   5. Wrap: CMP=0x10, CNT=0xFFFF_FFFE, en=1 -> after 2 edges CNT=0 and
//      flag stays 0.
//   6. Sync and reset: toggle sw_in to 0xA5A5 -> read 0x804 returns the old
//      value for 2 edges, then 0xA5A5. Assert reset_n=0 mid-count -> CNT=0,
//      LED=0 and irq=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder for the single-cycle ARM core: word RAM plus an MMIO page
// holding LED, synchronised switch and timer registers. Combinational loads, clocked stores.
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'h0000_0800,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MemWrite,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             irq
);

  localparam int unsigned RamAw    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RamBytes = 32'(RAM_WORDS * 4);

  localparam logic [5:0] OffLed  = 6'h00;
  localparam logic [5:0] OffSw   = 6'h01;
  localparam logic [5:0] OffCnt  = 6'h02;
  localparam logic [5:0] OffCmp  = 6'h03;
  localparam logic [5:0] OffCtrl = 6'h04;

  logic [31:0]      mem [RAM_WORDS];
  logic [RamAw-1:0] ram_idx;
  logic             ram_hit, mmio_hit;
  logic [5:0]       word_off;
  logic             unused_addr;

  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sync1_q, sync2_q;
  logic [31:0]      cnt_q, cnt_d, cmp_q;
  logic             en_q, ar_q, ie_q, flag_q, flag_d, flag_set;
  logic             led_wr, cnt_wr, cmp_wr, ctrl_wr;

  assign ram_idx     = Addr[RamAw+1:2];
  assign ram_hit     = (Addr < RamBytes);
  assign mmio_hit    = (Addr[31:8] == MMIO_BASE[31:8]);
  assign word_off    = Addr[7:2];
  assign unused_addr = ^Addr[1:0];

  assign led_wr  = MemWrite && mmio_hit && (word_off == OffLed);
  assign cnt_wr  = MemWrite && mmio_hit && (word_off == OffCnt);
  assign cmp_wr  = MemWrite && mmio_hit && (word_off == OffCmp);
  assign ctrl_wr = MemWrite && mmio_hit && (word_off == OffCtrl);

  // RAM is deliberately unreset; a store presented while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && MemWrite && ram_hit) begin
      mem[ram_idx] <= WriteData;
    end
  end

  // Timer: a CNT write pre-empts the match check; a match-set beats a same-cycle W1C.
  always_comb begin
    cnt_d    = cnt_q;
    flag_set = 1'b0;
    if (cnt_wr) begin
      cnt_d = WriteData;
    end else if (en_q && (cnt_q == cmp_q)) begin
      flag_set = 1'b1;
      cnt_d    = ar_q ? 32'd0 : cnt_q + 32'd1;
    end else if (en_q) begin
      cnt_d = cnt_q + 32'd1;
    end
    flag_d = flag_set | (flag_q & ~(ctrl_wr & WriteData[2]));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      en_q    <= 1'b0;
      ar_q    <= 1'b0;
      ie_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      if (led_wr) begin
        led_q <= WriteData[LED_W-1:0];
      end
      if (cmp_wr) begin
        cmp_q <= WriteData;
      end
      if (ctrl_wr) begin
        en_q <= WriteData[0];
        ar_q <= WriteData[1];
        ie_q <= WriteData[3];
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = mem[ram_idx];
    end else if (mmio_hit) begin
      case (word_off)
        OffLed:  ReadData[LED_W-1:0] = led_q;
        OffSw:   ReadData[SW_W-1:0]  = sync2_q;
        OffCnt:  ReadData            = cnt_q;
        OffCmp:  ReadData            = cmp_q;
        OffCtrl: ReadData            = {28'd0, ie_q, flag_q, ar_q, en_q};
        default: ReadData            = '0;
      endcase
    end
  end

  assign led_out = led_q;
  assign irq     = flag_q & ie_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: expectations are queued as stimulus is
// driven and popped when the corresponding load or output is sampled.
module tb_dmem_mmio_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        irq;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp, got;

  dmem_mmio_responder #(
    .RAM_WORDS(64),
    .MMIO_BASE(32'h0000_0800),
    .LED_W    (16),
    .SW_W     (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .sw_in    (sw_in),
    .led_out  (led_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // Store presented across one rising edge; returns 1 time unit after that edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5] = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h810};
    logic [31:0] vals  [5] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vals[i]);
      Addr = addrs[i];
      #1;
      got = ReadData;
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_read @%h: got %h expected %h", addrs[i], got, exp);
      end
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    got = {16'd0, led_out};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_led: got %h expected %h", got, exp);
    end
    got = {31'd0, irq};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_irq: got %h expected %h", got, exp);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_ram();
    logic [31:0] addrs [5] = '{32'h3C, 32'h3E, 32'h00, 32'hFC, 32'h100};
    store(32'h3C, 32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    exp_q.push_back(32'hDEAD_BEEF);
    store(32'h00, 32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    store(32'hFC, 32'hCAFE_F00D);
    exp_q.push_back(32'hCAFE_F00D);
    store(32'h100, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      Addr = addrs[i];
      #1;
      got = ReadData;
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL ram_read @%h: got %h expected %h", addrs[i], got, exp);
      end
    end
  endtask

  task automatic test_decode();
    logic [31:0] addrs [5] = '{32'h400, 32'h800, 32'h804, 32'h814, 32'h900};
    store(32'h400, 32'h5555_AAAA);
    exp_q.push_back(32'h0);
    store(32'h800, 32'hABCD_1234);
    exp_q.push_back(32'h0000_1234);
    got = {16'd0, led_out};
    exp = 32'h0000_1234;
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL led_out: got %h expected %h", got, exp);
    end
    store(32'h804, 32'h0000_FFFF);
    exp_q.push_back(32'h0);
    store(32'h814, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    store(32'h900, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      Addr = addrs[i];
      #1;
      got = ReadData;
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL decode_read @%h: got %h expected %h", addrs[i], got, exp);
      end
    end
  endtask

  task automatic test_timer();
    store(32'h80C, 32'd5);
    store(32'h810, 32'hB);
    store(32'h808, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back((k < 6) ? 32'(k) : 32'd0);
      exp_q.push_back((k == 6) ? 32'd1 : 32'd0);
      tick();
      Addr = 32'h808;
      #1;
      got = ReadData;
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL timer_cnt edge %0d: got %h expected %h", k, got, exp);
      end
      got = {31'd0, irq};
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL timer_irq edge %0d: got %h expected %h", k, got, exp);
      end
    end
    store(32'h810, 32'hF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hB);
    got = {31'd0, irq};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL timer_w1c_irq: got %h expected %h", got, exp);
    end
    Addr = 32'h810;
    #1;
    got = ReadData;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL timer_w1c_ctrl: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_collision();
    // CNT=1 here; load 5 so the next edge is a match edge.
    store(32'h808, 32'd5);
    store(32'h810, 32'hF);
    exp_q.push_back(32'hF);
    exp_q.push_back(32'h1);
    Addr = 32'h810;
    #1;
    got = ReadData;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL collision_w1c_ctrl: got %h expected %h", got, exp);
    end
    got = {31'd0, irq};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL collision_w1c_irq: got %h expected %h", got, exp);
    end
    store(32'h810, 32'hF);
    store(32'h808, 32'd5);
    store(32'h808, 32'h77);
    exp_q.push_back(32'h77);
    exp_q.push_back(32'hB);
    Addr = 32'h808;
    #1;
    got = ReadData;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL collision_cnt_value: got %h expected %h", got, exp);
    end
    Addr = 32'h810;
    #1;
    got = ReadData;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL collision_cnt_flag: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] cnts [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    store(32'h810, 32'h0);
    store(32'h80C, 32'h10);
    store(32'h808, 32'hFFFF_FFFE);
    store(32'h810, 32'h1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      exp_q.push_back(cnts[k]);
      Addr = 32'h808;
      #1;
      got = ReadData;
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL wrap_cnt step %0d: got %h expected %h", k, got, exp);
      end
    end
    exp_q.push_back(32'h1);
    Addr = 32'h810;
    #1;
    got = ReadData;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL wrap_flag: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_sync_reset();
    logic [31:0] sw_exp [3] = '{32'h0, 32'h0, 32'h0000_A5A5};
    logic [31:0] rst_addr [4] = '{32'h808, 32'h80C, 32'h810, 32'h804};
    logic [31:0] rst_exp  [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    tick();
    sw_in = 16'hA5A5;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      exp_q.push_back(sw_exp[k]);
      Addr = 32'h804;
      #1;
      got = ReadData;
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL sw_sync edge %0d: got %h expected %h", k, got, exp);
      end
    end
    // Counter runs through a match (flag+irq) before reset lands mid-cycle.
    store(32'h800, 32'h55);
    store(32'h80C, 32'd2);
    store(32'h808, 32'd0);
    store(32'h810, 32'h9);
    tick();
    tick();
    tick();
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd1);
    Addr = 32'h808;
    #1;
    got = ReadData;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL prereset_cnt: got %h expected %h", got, exp);
    end
    got = {31'd0, irq};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL prereset_irq: got %h expected %h", got, exp);
    end
    #1 reset_n = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    got = {16'd0, led_out};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL async_reset_led: got %h expected %h", got, exp);
    end
    got = {31'd0, irq};
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL async_reset_irq: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rst_exp[i]);
      Addr = rst_addr[i];
      #0.5;
      got = ReadData;
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL async_reset_read @%h: got %h expected %h", rst_addr[i], got, exp);
      end
    end
    store(32'h3C, 32'h1111_1111);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    Addr = 32'h3C;
    #1;
    got = ReadData;
    exp = exp_q.pop_front();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_store_lost: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_decode();
    test_timer();
    test_collision();
    test_wrap();
    test_sync_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
